matmul_result_drain: RTL

Output-side sequencer for the matrix-multiply datapath. The compute controller loads operands and steps the MAC array. When it signals that results are ready, this block captures all MAC accumulator values in one cycle and clears the MACs so the next computation can start. It then streams the captured results one word per transfer over a valid/ready interface, converting each accumulator to the output word width.

---
 rtl/matmul_result_drain.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/matmul_result_drain.sv
// matmul_result_drain
//
// Output-side sequencer for the matrix-multiply datapath. On a start pulse it
// captures every MAC accumulator into a local buffer in a single cycle. It
// pulses mac_clr so the MAC array can begin the next computation. It then
// streams the buffered words, one per valid/ready transfer, each converted to
// DATA_W bits.
//
// Build option:
//   MATMUL_OUT_SAT_EN  defined   -> conversion saturates to the signed DATA_W range
//                      undefined -> conversion keeps the low DATA_W bits (truncation)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       one-cycle pulse: the accumulators hold final results
//   acc_bus     N_RES accumulators, result k at [k*ACC_W +: ACC_W]
//   mac_clr     one-cycle pulse clearing the MAC accumulators after capture
//   busy        high while captured words remain to be sent
//   dout        current result word
//   dout_valid  dout holds a valid word
//   dout_ready  sink accepts the word
//   dout_last   marks the word at index N_RES-1
//   done        one-cycle pulse after the last word is accepted
//   overrun     sticky: start arrived while busy (cleared only by reset)

module matmul_result_drain #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 34,
    parameter int N_RES  = 4,
    parameter int IDX_W  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [N_RES*ACC_W-1:0] acc_bus,
    output logic                   mac_clr,
    output logic                   busy,
    output logic [DATA_W-1:0]      dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    output logic                   done,
    output logic                   overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RES - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] buffer    [N_RES];
    logic [DATA_W-1:0] conv_word [N_RES];

    // Accumulator-to-word conversion, evaluated for all results in parallel.
`ifdef MATMUL_OUT_SAT_EN
    // The value fits in DATA_W signed bits when every bit from DATA_W-1 up to
    // the sign bit equals the sign; otherwise clamp toward the sign.
    logic [ACC_W-DATA_W:0] hi;

    always_comb begin
        hi = '0;
        for (int unsigned k = 0; k < N_RES; k++) begin
            hi = acc_bus[k*ACC_W + DATA_W - 1 +: ACC_W - DATA_W + 1];
            if ((hi == '0) || (hi == '1)) begin
                conv_word[k] = acc_bus[k*ACC_W +: DATA_W];
            end else if (hi[ACC_W-DATA_W]) begin
                conv_word[k] = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                conv_word[k] = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end
`else
    // Truncation discards the accumulator high bits; they are folded into a
    // dummy reduction only so they are not reported as dangling inputs.
    logic unused_acc_hi;

    always_comb begin
        unused_acc_hi = 1'b0;
        for (int unsigned k = 0; k < N_RES; k++) begin
            conv_word[k]  = acc_bus[k*ACC_W +: DATA_W];
            unused_acc_hi = unused_acc_hi
                          ^ (^acc_bus[k*ACC_W + DATA_W - 1 +: ACC_W - DATA_W + 1]);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            mac_clr <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            for (int unsigned k = 0; k < N_RES; k++) begin
                buffer[k] <= '0;
            end
        end else begin
            mac_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned k = 0; k < N_RES; k++) begin
                            buffer[k] <= conv_word[k];
                        end
                        idx     <= '0;
                        mac_clr <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    // A start here would overwrite words not yet sent, so it
                    // is dropped and only flagged.
                    if (start) begin
                        overrun <= 1'b1;
                    end
                    if (dout_ready) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stream outputs are decoded from registered state only (no input path).
    assign busy       = (state == SEND);
    assign dout_valid = (state == SEND);
    assign dout_last  = (state == SEND) && (idx == LAST_IDX);
    assign dout       = (state == SEND) ? buffer[idx] : '0;

endmodule
